// File: rtl/tick_pkg.sv
// Shared constants and width helper for the alarm-clock timebase.
package tick_pkg;

    localparam int unsigned DEF_CLK_HZ      = 256;
    localparam int unsigned DEF_SEC_PER_MIN = 60;
    localparam int unsigned DEF_MIN_PER_HR  = 60;

    // Counter width for a modulus-n counter; a modulus of 1 still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulus-MOD up-counter with hold, synchronous clear and a terminal-count flag.
module mod_counter
    import tick_pkg::*;
#(
    parameter int unsigned MOD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    inc,
    output logic [cnt_w(MOD)-1:0]   value,
    output logic                    term_c
);

    localparam int unsigned W = cnt_w(MOD);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Full-width terminal compare so non-power-of-2 moduli wrap exactly.
    assign term_c = (value == LAST) && inc;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= term_c ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Timebase producing one_second / one_minute strobes for the alarm clock.
// Define TICK_HOUR_EN to add the minute counter and the one_hour strobe.
module tick_gen
    import tick_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned SEC_PER_MIN = DEF_SEC_PER_MIN,
    parameter int unsigned MIN_PER_HR  = DEF_MIN_PER_HR
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            reset_count,
    input  logic                            run,
    input  logic                            fast_watch,
    output logic                            one_second,
    output logic                            one_minute,
`ifdef TICK_HOUR_EN
    output logic                            one_hour,
`endif
    output logic [cnt_w(SEC_PER_MIN)-1:0]   sec_count
);

    localparam int unsigned PRE_W = cnt_w(CLK_HZ);

    if (CLK_HZ < 2 || SEC_PER_MIN < 2 || MIN_PER_HR < 1) begin : g_bad_param
        $error("tick_gen: CLK_HZ and SEC_PER_MIN must be >= 2, MIN_PER_HR >= 1");
    end

    logic [PRE_W-1:0] pre;
    logic             sec_tick;
    logic             min_tick;
    logic             min_adv;

    mod_counter #(.MOD(CLK_HZ)) u_pre (
        .clk    (clk),
        .reset  (reset),
        .clr    (reset_count),
        .inc    (run),
        .value  (pre),
        .term_c (sec_tick)
    );

    mod_counter #(.MOD(SEC_PER_MIN)) u_sec (
        .clk    (clk),
        .reset  (reset),
        .clr    (reset_count),
        .inc    (sec_tick),
        .value  (sec_count),
        .term_c (min_tick)
    );

    // In fast mode the minute rate collapses onto the second rate.
    assign min_adv = fast_watch ? sec_tick : min_tick;

`ifdef TICK_HOUR_EN
    logic [cnt_w(MIN_PER_HR)-1:0] min_count;
    logic                         hour_tick;

    mod_counter #(.MOD(MIN_PER_HR)) u_min (
        .clk    (clk),
        .reset  (reset),
        .clr    (reset_count),
        .inc    (min_adv),
        .value  (min_count),
        .term_c (hour_tick)
    );

    always_ff @(posedge clk) begin
        if (reset || reset_count) begin
            one_hour <= 1'b0;
        end else begin
            one_hour <= hour_tick;
        end
    end

    a_hour_wrap: assert property (@(posedge clk) disable iff (reset) one_hour |-> (min_count == '0));
`endif

    // Strobes are suppressed on any restart edge; run=0 already gates sec_tick.
    always_ff @(posedge clk) begin
        if (reset || reset_count) begin
            one_second <= 1'b0;
            one_minute <= 1'b0;
        end else begin
            one_second <= sec_tick;
            one_minute <= min_adv;
        end
    end

    a_sec_wrap: assert property (@(posedge clk) disable iff (reset) one_second |-> (pre == '0));

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: a 256 Hz / 4 s-per-minute instance and a 2 Hz boundary instance.
`timescale 1ns/1ps
module tb_tick_gen;

    logic       clk;
    logic       a_reset, a_rc, a_run, a_fast;
    logic       a_sec, a_min;
    logic [1:0] a_cnt;
    logic       b_reset, b_rc, b_run, b_fast;
    logic       b_sec, b_min;
    logic [0:0] b_cnt;
`ifdef TICK_HOUR_EN
    logic       a_hour, b_hour;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    tick_gen #(.CLK_HZ(256), .SEC_PER_MIN(4), .MIN_PER_HR(60)) dut_a (
        .clk         (clk),
        .reset       (a_reset),
        .reset_count (a_rc),
        .run         (a_run),
        .fast_watch  (a_fast),
        .one_second  (a_sec),
        .one_minute  (a_min),
`ifdef TICK_HOUR_EN
        .one_hour    (a_hour),
`endif
        .sec_count   (a_cnt)
    );

    tick_gen #(.CLK_HZ(2), .SEC_PER_MIN(2), .MIN_PER_HR(3)) dut_b (
        .clk         (clk),
        .reset       (b_reset),
        .reset_count (b_rc),
        .run         (b_run),
        .fast_watch  (b_fast),
        .one_second  (b_sec),
        .one_minute  (b_min),
`ifdef TICK_HOUR_EN
        .one_hour    (b_hour),
`endif
        .sec_count   (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Cycle n is sampled 1ns after the n-th edge following reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_a(input logic fast);
        a_reset = 1'b1; a_rc = 1'b0; a_run = 1'b1; a_fast = fast;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        check("a_rst_sec", 32'(a_sec), 0);
        check("a_rst_min", 32'(a_min), 0);
        check("a_rst_cnt", 32'(a_cnt), 0);
`ifdef TICK_HOUR_EN
        check("a_rst_hour", 32'(a_hour), 0);
`endif
        a_reset = 1'b0;
    endtask

    task automatic reset_b(input logic fast);
        b_reset = 1'b1; b_rc = 1'b0; b_run = 1'b1; b_fast = fast;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        check("b_rst_sec", 32'(b_sec), 0);
        check("b_rst_min", 32'(b_min), 0);
        check("b_rst_cnt", 32'(b_cnt), 0);
`ifdef TICK_HOUR_EN
        check("b_rst_hour", 32'(b_hour), 0);
`endif
        b_reset = 1'b0;
    endtask

    initial begin
        b_reset = 1'b1; b_rc = 1'b0; b_run = 1'b1; b_fast = 1'b0;

        // Basic rate: seconds every 256 cycles, minute on the 4th second.
        reset_a(1'b0);
        for (int i = 0; i < 1100; i++) begin
            tick();
            check("basic_sec", 32'(a_sec), 32'(cyc % 256 == 0));
            check("basic_min", 32'(a_min), 32'(cyc == 1024));
            check("basic_cnt", 32'(a_cnt), 32'((cyc / 256) % 4));
        end

        // Fast watch, dropped after cycle 600: next minute only at 1024.
        reset_a(1'b1);
        for (int i = 0; i < 1100; i++) begin
            tick();
            check("fast_sec", 32'(a_sec), 32'(cyc % 256 == 0));
            check("fast_min", 32'(a_min), 32'((cyc % 256 == 0 && cyc <= 600) || cyc == 1024));
            check("fast_cnt", 32'(a_cnt), 32'((cyc / 256) % 4));
            if (cyc == 600) a_fast = 1'b0;
        end

        // Pause for 50 cycles from cycle 100: first second slips to 306.
        reset_a(1'b0);
        for (int i = 0; i < 400; i++) begin
            tick();
            check("pause_sec", 32'(a_sec), 32'(cyc == 306));
            check("pause_min", 32'(a_min), 0);
            check("pause_cnt", 32'(a_cnt), 32'(cyc >= 306));
            if (cyc == 100) a_run = 1'b0;
            if (cyc == 150) a_run = 1'b1;
        end

        // Restart on the edge where the first strobe is due.
        reset_a(1'b0);
        for (int i = 0; i < 600; i++) begin
            tick();
            check("rst_cnt_sec", 32'(a_sec), 32'(cyc == 512));
            check("rst_cnt_min", 32'(a_min), 0);
            check("rst_cnt_cnt", 32'(a_cnt), 32'(cyc >= 512));
            if (cyc == 255) a_rc = 1'b1;
            if (cyc == 256) a_rc = 1'b0;
        end

        // Boundary moduli: second every 2, minute every 4, hour every 12.
        reset_b(1'b0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("bnd_sec", 32'(b_sec), 32'(cyc % 2 == 0));
            check("bnd_min", 32'(b_min), 32'(cyc % 4 == 0));
            check("bnd_cnt", 32'(b_cnt), 32'((cyc / 2) % 2));
`ifdef TICK_HOUR_EN
            check("bnd_hour", 32'(b_hour), 32'(cyc % 12 == 0));
`endif
        end

        // Boundary moduli in fast mode: minute every 2, hour every 6.
        reset_b(1'b1);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("bndf_sec", 32'(b_sec), 32'(cyc % 2 == 0));
            check("bndf_min", 32'(b_min), 32'(cyc % 2 == 0));
`ifdef TICK_HOUR_EN
            check("bndf_hour", 32'(b_hour), 32'(cyc % 6 == 0));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
